// File: rtl/cache_pkg.sv
// Shared definitions for the MEM-stage data cache: FSM state encodings,
// derived geometry and address field extraction helpers.
package cache_pkg;

    localparam int unsigned OFFSET_BITS_DEFAULT = 2;
    localparam int unsigned INDEX_BITS_DEFAULT  = 4;

    // Controller states, kept as plain 2-bit encodings
    localparam logic [1:0] COMPARE    = 2'd0;
    localparam logic [1:0] WRITE_BACK = 2'd1;
    localparam logic [1:0] ALLOCATE   = 2'd2;

    function automatic int unsigned tag_bits(input int unsigned offset_bits,
                                             input int unsigned index_bits);
        return 30 - offset_bits - index_bits;
    endfunction

    function automatic int unsigned line_words(input int unsigned offset_bits);
        return 1 << offset_bits;
    endfunction

    localparam int unsigned TAG_BITS   = tag_bits(OFFSET_BITS_DEFAULT, INDEX_BITS_DEFAULT);
    localparam int unsigned LINE_WORDS = line_words(OFFSET_BITS_DEFAULT);

    // Word offset within the line, right-aligned
    function automatic logic [31:0] addr_offset(input logic [31:0] addr,
                                                input int unsigned offset_bits);
        return (addr >> 2) & ((32'd1 << offset_bits) - 32'd1);
    endfunction

    // Line index, right-aligned
    function automatic logic [31:0] addr_index(input logic [31:0] addr,
                                               input int unsigned offset_bits,
                                               input int unsigned index_bits);
        return (addr >> (offset_bits + 2)) & ((32'd1 << index_bits) - 32'd1);
    endfunction

    // Tag: everything above the index, right-aligned
    function automatic logic [31:0] addr_tag(input logic [31:0] addr,
                                             input int unsigned offset_bits,
                                             input int unsigned index_bits);
        return addr >> (offset_bits + index_bits + 2);
    endfunction

endpackage

// File: rtl/cache_ram.sv
// Line storage for the data cache: valid/dirty flags, tags and data words.
// Reads are asynchronous; writes land on the rising edge; reset clears flags only.
import cache_pkg::*;

module cache_ram #(
    parameter int unsigned OFFSET_BITS = 2,
    parameter int unsigned INDEX_BITS  = 4,
    parameter int unsigned TAG_BITS    = 24
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [INDEX_BITS-1:0]  rd_index,
    input  logic [OFFSET_BITS-1:0] rd_offset,
    output logic                   rd_valid,
    output logic                   rd_dirty,
    output logic [TAG_BITS-1:0]    rd_tag,
    output logic [31:0]            rd_word,
    input  logic                   word_we,
    input  logic [INDEX_BITS-1:0]  word_index,
    input  logic [OFFSET_BITS-1:0] word_offset,
    input  logic [31:0]            word_data,
    input  logic                   meta_we,
    input  logic [INDEX_BITS-1:0]  meta_index,
    input  logic [TAG_BITS-1:0]    meta_tag,
    input  logic                   meta_valid,
    input  logic                   meta_dirty
);

    localparam int unsigned LINES = 1 << INDEX_BITS;
    localparam int unsigned WORDS = 1 << OFFSET_BITS;

    logic [LINES-1:0]    valid_bits;
    logic [LINES-1:0]    dirty_bits;
    logic [TAG_BITS-1:0] tag_mem  [LINES];
    logic [31:0]         data_mem [LINES*WORDS];

    assign rd_valid = valid_bits[rd_index];
    assign rd_dirty = dirty_bits[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_word  = data_mem[{rd_index, rd_offset}];

    // Line flags: cleared asynchronously so a reset invalidates every line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_bits <= '0;
            dirty_bits <= '0;
        end else if (meta_we) begin
            valid_bits[meta_index] <= meta_valid;
            dirty_bits[meta_index] <= meta_dirty;
        end
    end

    // Tag and data arrays carry no reset; their contents only matter once valid
    always_ff @(posedge clk) begin
        if (word_we) begin
            data_mem[{word_index, word_offset}] <= word_data;
        end
        if (meta_we) begin
            tag_mem[meta_index] <= meta_tag;
        end
    end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache controller for the
// MEM stage. Misses stall the pipeline through cache_miss_o while a dirty
// victim is written back and the line is refilled one word per handshake.
import cache_pkg::*;

module data_cache #(
    parameter int unsigned OFFSET_BITS = 2,
    parameter int unsigned INDEX_BITS  = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] write_data_i,
    output logic [31:0] read_data_o,
    output logic        cache_miss_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ready_i
);

    localparam int unsigned LOCAL_TAG_BITS = tag_bits(OFFSET_BITS, INDEX_BITS);
    localparam logic [OFFSET_BITS-1:0] LAST_BEAT = '1;

    logic [1:0]                state;
    logic [1:0]                next_state;
    logic [OFFSET_BITS-1:0]    beat;
    logic [OFFSET_BITS-1:0]    next_beat;
    logic [INDEX_BITS-1:0]     burst_index;
    logic [LOCAL_TAG_BITS-1:0] burst_tag;

    logic [OFFSET_BITS-1:0]    req_offset;
    logic [INDEX_BITS-1:0]     req_index;
    logic [LOCAL_TAG_BITS-1:0] req_tag;

    logic                      in_compare;
    logic                      active;
    logic                      hit;
    logic                      miss_start;
    logic                      read_hit;
    logic                      write_hit;

    logic [INDEX_BITS-1:0]     ram_index;
    logic [OFFSET_BITS-1:0]    ram_offset;
    logic                      rd_valid;
    logic                      rd_dirty;
    logic [LOCAL_TAG_BITS-1:0] rd_tag;
    logic [31:0]               rd_word;

    logic                      word_we;
    logic [31:0]               word_data;
    logic                      meta_we;
    logic [LOCAL_TAG_BITS-1:0] meta_tag;
    logic                      meta_dirty;

    assign req_offset = OFFSET_BITS'(addr_offset(addr_i, OFFSET_BITS));
    assign req_index  = INDEX_BITS'(addr_index(addr_i, OFFSET_BITS, INDEX_BITS));
    assign req_tag    = LOCAL_TAG_BITS'(addr_tag(addr_i, OFFSET_BITS, INDEX_BITS));

    assign in_compare = (state == COMPARE);
    assign active     = mem_read_i | mem_write_i;

    // Bursts use the index latched at miss time so a request that drops
    // mid-miss still finishes against the right line.
    assign ram_index  = in_compare ? req_index  : burst_index;
    assign ram_offset = in_compare ? req_offset : beat;

    assign hit        = rd_valid && (rd_tag == req_tag);
    assign miss_start = in_compare && active && !hit;
    assign write_hit  = in_compare && mem_write_i && hit;
    assign read_hit   = in_compare && mem_read_i && !mem_write_i && hit;

    cache_ram #(
        .OFFSET_BITS (OFFSET_BITS),
        .INDEX_BITS  (INDEX_BITS),
        .TAG_BITS    (LOCAL_TAG_BITS)
    ) u_ram (
        .clk         (clk_i),
        .rst_n       (rst_ni),
        .rd_index    (ram_index),
        .rd_offset   (ram_offset),
        .rd_valid    (rd_valid),
        .rd_dirty    (rd_dirty),
        .rd_tag      (rd_tag),
        .rd_word     (rd_word),
        .word_we     (word_we),
        .word_index  (ram_index),
        .word_offset (ram_offset),
        .word_data   (word_data),
        .meta_we     (meta_we),
        .meta_index  (ram_index),
        .meta_tag    (meta_tag),
        .meta_valid  (1'b1),
        .meta_dirty  (meta_dirty)
    );

    // Next-state, beat counter and storage write control
    always_comb begin
        next_state = state;
        next_beat  = beat;
        word_we    = 1'b0;
        word_data  = write_data_i;
        meta_we    = 1'b0;
        meta_tag   = req_tag;
        meta_dirty = 1'b1;
        case (state)
            COMPARE: begin
                if (write_hit) begin
                    word_we = 1'b1;
                    meta_we = 1'b1;
                end else if (miss_start) begin
                    next_state = (rd_valid && rd_dirty) ? WRITE_BACK : ALLOCATE;
                end
            end
            WRITE_BACK: begin
                if (mem_ready_i) begin
                    next_beat = beat + 1'b1;
                    if (beat == LAST_BEAT) begin
                        next_state = ALLOCATE;
                    end
                end
            end
            ALLOCATE: begin
                if (mem_ready_i) begin
                    word_we   = 1'b1;
                    word_data = mem_rdata_i;
                    next_beat = beat + 1'b1;
                    if (beat == LAST_BEAT) begin
                        meta_we    = 1'b1;
                        meta_tag   = burst_tag;
                        meta_dirty = 1'b0;
                        next_state = COMPARE;
                    end
                end
            end
            default: begin
                next_state = COMPARE;
                next_beat  = '0;
            end
        endcase
    end

    // FSM state, beat counter and latched burst line
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= COMPARE;
            beat        <= '0;
            burst_index <= '0;
            burst_tag   <= '0;
        end else begin
            state <= next_state;
            beat  <= next_beat;
            if (miss_start) begin
                burst_index <= req_index;
                burst_tag   <= req_tag;
            end
        end
    end

    assign cache_miss_o = in_compare ? miss_start : 1'b1;
    assign read_data_o  = read_hit ? rd_word : '0;
    assign mem_req_o    = !in_compare;
    assign mem_we_o     = (state == WRITE_BACK);
    assign mem_wdata_o  = (state == WRITE_BACK) ? rd_word : '0;
    assign mem_addr_o   = (state == WRITE_BACK) ? {rd_tag, burst_index, beat, 2'b00} :
                          (state == ALLOCATE)   ? {burst_tag, burst_index, beat, 2'b00} :
                                                  '0;

endmodule
